// File: rtl/nmea_pkg.sv
// Shared types for the NMEA sentence scheduler: FSM states, the queued record layout and a
// saturating counter helper.
package nmea_pkg;

  localparam int unsigned NMEA_REC_W = 48;

  typedef enum logic [1:0] {DISABLED, HUNT, LOCKED, LOST} sched_state_e;

  typedef struct packed {
    logic [7:0]  fields;
    logic [23:0] id;
    logic [15:0] talker;
  } nmea_rec_t;

  function automatic logic [15:0] sat_inc(logic [15:0] v, logic ev);
    return (ev && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/nmea_sentence_sched_if.sv
// Record stream from the scheduler FIFO to downstream parsers (valid/ready).
interface nmea_sentence_sched_if;
  import nmea_pkg::*;

  logic      o_rec_valid;
  logic      i_rec_ready;
  nmea_rec_t o_rec_data;

  modport master (output o_rec_valid, output o_rec_data, input i_rec_ready);
  modport slave  (input o_rec_valid, input o_rec_data, output i_rec_ready);

endinterface

// File: rtl/nmea_rec_fifo.sv
// Small synchronous FIFO for accepted sentence headers; no empty bypass, push allowed when full
// only if a pop happens in the same cycle.
module nmea_rec_fifo
  import nmea_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         rec_t = nmea_rec_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  input  logic i_push,
  input  rec_t i_data,
  input  logic i_pop,
  output logic o_valid,
  output rec_t o_data,
  output logic o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign o_valid = (cnt_q != '0);
  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_data  = o_valid ? mem[rd_q] : '0;
  assign do_pop  = i_pop & o_valid;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_q] <= i_data;
  end

endmodule

// File: rtl/nmea_sentence_sched.sv
// Sentence ID filter, header FIFO, link watchdog and receiver sequencing FSM.
// Optional statistics counters are built when NMEA_SCHED_STATS_EN is defined.
module nmea_sentence_sched
  import nmea_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NFILT   = 4,
  parameter int unsigned TIMEOUT = 50_000_000,
  parameter int unsigned TO_W    = 26
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_s_done,
  input  logic                     i_s_check,
  input  logic [15:0]              i_s_talker,
  input  logic [23:0]              i_s_id,
  input  logic [7:0]               i_s_fields,
  output logic                     o_rx_en,
  output logic                     o_rx_flush,
  input  logic                     i_cfg_we,
  input  logic [$clog2(NFILT)-1:0] i_cfg_idx,
  input  logic [23:0]              i_cfg_id,
  input  logic                     i_cfg_on,
  nmea_sentence_sched_if.master    rec,
  output logic                     o_locked,
  output logic                     o_drop
`ifdef NMEA_SCHED_STATS_EN
  ,
  output logic [15:0]              o_cnt_good,
  output logic [15:0]              o_cnt_bad,
  output logic [15:0]              o_cnt_drop,
  output logic [15:0]              o_cnt_lost
`endif
);

  sched_state_e     state_q, state_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             flush_q, flush_d, drop_q, lost_evt;
  logic [23:0]      filt_id_q [NFILT];
  logic [NFILT-1:0] filt_on_q;
  logic             good, expire, hit, accept, push, full, drop_evt;
  nmea_rec_t        rec_in;

  assign good   = i_s_done & i_s_check;
  assign expire = (wd_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < NFILT; k++) begin
      if (filt_on_q[k] && (filt_id_q[k] == i_s_id)) hit = 1'b1;
    end
  end

  // An empty filter table means accept-all.
  assign accept   = good & (~|filt_on_q | hit);
  assign push     = accept & i_en & (state_q != DISABLED);
  assign drop_evt = push & full & ~(rec.o_rec_valid & rec.i_rec_ready);
  assign rec_in   = '{fields: i_s_fields, id: i_s_id, talker: i_s_talker};

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    flush_d  = 1'b0;
    lost_evt = 1'b0;
    if (!i_en) begin
      state_d = DISABLED;
      wd_d    = '0;
    end else begin
      case (state_q)
        DISABLED: begin
          state_d = HUNT;
          wd_d    = '0;
        end
        HUNT: begin
          if (good) begin
            state_d = LOCKED;
            wd_d    = '0;
          end else if (expire) begin
            wd_d    = '0;
            flush_d = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        LOCKED: begin
          if (good) begin
            wd_d = '0;
          end else if (expire) begin
            state_d  = LOST;
            wd_d     = '0;
            flush_d  = 1'b1;
            lost_evt = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        LOST: begin
          state_d = HUNT;
          if (good) wd_d = '0;
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= DISABLED;
      wd_q    <= '0;
      flush_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      flush_q <= flush_d;
      drop_q  <= drop_evt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      filt_on_q <= '0;
      for (int unsigned k = 0; k < NFILT; k++) filt_id_q[k] <= '0;
    end else if (i_cfg_we) begin
      filt_on_q[i_cfg_idx] <= i_cfg_on;
      filt_id_q[i_cfg_idx] <= i_cfg_id;
    end
  end

  nmea_rec_fifo #(
    .DEPTH (DEPTH),
    .rec_t (nmea_rec_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (~i_en),
    .i_push  (push),
    .i_data  (rec_in),
    .i_pop   (rec.i_rec_ready),
    .o_valid (rec.o_rec_valid),
    .o_data  (rec.o_rec_data),
    .o_full  (full)
  );

  assign o_rx_en    = (state_q == HUNT) || (state_q == LOCKED);
  assign o_locked   = (state_q == LOCKED);
  assign o_rx_flush = flush_q;
  assign o_drop     = drop_q;

`ifdef NMEA_SCHED_STATS_EN
  logic [15:0] cnt_good_q, cnt_bad_q, cnt_drop_q, cnt_lost_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
      cnt_drop_q <= '0;
      cnt_lost_q <= '0;
    end else begin
      cnt_good_q <= sat_inc(cnt_good_q, good);
      cnt_bad_q  <= sat_inc(cnt_bad_q, i_s_done & ~i_s_check);
      cnt_drop_q <= sat_inc(cnt_drop_q, drop_evt);
      cnt_lost_q <= sat_inc(cnt_lost_q, lost_evt);
    end
  end

  assign o_cnt_good = cnt_good_q;
  assign o_cnt_bad  = cnt_bad_q;
  assign o_cnt_drop = cnt_drop_q;
  assign o_cnt_lost = cnt_lost_q;
`endif

endmodule

// File: tb/tb_nmea_sentence_sched.sv
// Bench for nmea_sentence_sched: directed scenarios followed by randomized traffic, all checked
// against a queue-based behavioural model of the scheduler.
module tb_nmea_sentence_sched;
  import nmea_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NFILT   = 4;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned TO_W    = 7;
  localparam logic [23:0] ID_GGA  = 24'h414747;
  localparam logic [23:0] ID_RMC  = 24'h434D52;
  localparam logic [23:0] ID_GSV  = 24'h565347;
  localparam logic [15:0] TK_GP   = 16'h5047;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic        s_done = 1'b0, s_check = 1'b0;
  logic [15:0] s_talker = '0;
  logic [23:0] s_id = '0;
  logic [7:0]  s_fields = '0;
  logic        rx_en, rx_flush, locked, drop;
  logic        cfg_we = 1'b0, cfg_on = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [23:0] cfg_id = '0;
`ifdef NMEA_SCHED_STATS_EN
  logic [15:0] cnt_good, cnt_bad, cnt_drop, cnt_lost;
`endif

  nmea_sentence_sched_if rec_if ();

  nmea_sentence_sched #(
    .DEPTH   (DEPTH),
    .NFILT   (NFILT),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_s_done   (s_done),
    .i_s_check  (s_check),
    .i_s_talker (s_talker),
    .i_s_id     (s_id),
    .i_s_fields (s_fields),
    .o_rx_en    (rx_en),
    .o_rx_flush (rx_flush),
    .i_cfg_we   (cfg_we),
    .i_cfg_idx  (cfg_idx),
    .i_cfg_id   (cfg_id),
    .i_cfg_on   (cfg_on),
    .rec        (rec_if),
    .o_locked   (locked),
    .o_drop     (drop)
`ifdef NMEA_SCHED_STATS_EN
    ,
    .o_cnt_good (cnt_good),
    .o_cnt_bad  (cnt_bad),
    .o_cnt_drop (cnt_drop),
    .o_cnt_lost (cnt_lost)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 disabled, 1 hunting, 2 locked, 3 lost.
  int          m_state = 0;
  int          m_wd = 0;
  logic [47:0] m_q [$];
  logic [23:0] m_fid [NFILT];
  bit          m_fon [NFILT];
  bit          m_flush = 0, m_drop = 0;
  int          m_good = 0, m_bad = 0, m_dropc = 0, m_lost = 0;

  task automatic chk(string tag, logic [47:0] obs, logic [47:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_edge();
    bit good, pop, any_on, hit, acc;
    good = s_done && s_check;
    pop  = (m_q.size() != 0) && rec_if.i_rec_ready;
    if (rst) begin
      m_state = 0; m_wd = 0; m_q.delete(); m_flush = 0; m_drop = 0;
      m_good = 0; m_bad = 0; m_dropc = 0; m_lost = 0;
      for (int k = 0; k < NFILT; k++) begin m_fid[k] = '0; m_fon[k] = 0; end
      return;
    end
    if (good) m_good = sat(m_good);
    if (s_done && !s_check) m_bad = sat(m_bad);
    any_on = 0; hit = 0;
    for (int k = 0; k < NFILT; k++) begin
      if (m_fon[k]) begin
        any_on = 1;
        if (m_fid[k] == s_id) hit = 1;
      end
    end
    acc = good && (!any_on || hit);
    m_flush = 0; m_drop = 0;
    if (!en) begin
      m_state = 0; m_wd = 0; m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_state != 0 && acc) begin
        if (m_q.size() < DEPTH) m_q.push_back({s_fields, s_id, s_talker});
        else begin m_drop = 1; m_dropc = sat(m_dropc); end
      end
      case (m_state)
        0: begin m_state = 1; m_wd = 0; end
        1: begin
          if (good) begin m_state = 2; m_wd = 0; end
          else if (m_wd == TIMEOUT - 1) begin m_wd = 0; m_flush = 1; end
          else m_wd++;
        end
        2: begin
          if (good) m_wd = 0;
          else if (m_wd == TIMEOUT - 1) begin
            m_state = 3; m_wd = 0; m_flush = 1; m_lost = sat(m_lost);
          end else m_wd++;
        end
        default: begin m_state = 1; if (good) m_wd = 0; end
      endcase
    end
    if (cfg_we) begin m_fid[cfg_idx] = cfg_id; m_fon[cfg_idx] = cfg_on; end
  endtask

  task automatic check_all();
    logic [47:0] data;
    data = rec_if.o_rec_data;
    chk("valid", rec_if.o_rec_valid, m_q.size() != 0);
    chk("data", data, (m_q.size() != 0) ? m_q[0] : 48'h0);
    chk("locked", locked, m_state == 2);
    chk("rx_en", rx_en, (m_state == 1) || (m_state == 2));
    chk("rx_flush", rx_flush, m_flush);
    chk("drop", drop, m_drop);
`ifdef NMEA_SCHED_STATS_EN
    chk("cnt_good", cnt_good, m_good);
    chk("cnt_bad", cnt_bad, m_bad);
    chk("cnt_drop", cnt_drop, m_dropc);
    chk("cnt_lost", cnt_lost, m_lost);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(logic [15:0] t, logic [23:0] id, logic [7:0] f, logic ck);
    s_done = 1'b1; s_check = ck; s_talker = t; s_id = id; s_fields = f;
    step();
    s_done = 1'b0; s_check = 1'b0;
  endtask

  task automatic cfg(logic [1:0] idx, logic [23:0] id, logic on);
    cfg_we = 1'b1; cfg_idx = idx; cfg_id = id; cfg_on = on;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [47:0] d;
    logic [23:0] ids [3];
    int n;
    ids[0] = ID_GGA; ids[1] = ID_RMC; ids[2] = ID_GSV;
    rec_if.i_rec_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_valid", rec_if.o_rec_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    rst = 1'b0; en = 1'b1;
    step();
    chk("t1_hunt_rx_en", rx_en, 1'b1);

    // T1: no filters, GGA accepted, lock acquired
    send(TK_GP, ID_GGA, 8'd14, 1'b1);
    d = rec_if.o_rec_data;
    chk("t1_valid", rec_if.o_rec_valid, 1'b1);
    chk("t1_data", d, {8'd14, 24'h414747, 16'h5047});
    chk("t1_locked", locked, 1'b1);
    rec_if.i_rec_ready = 1'b1; step(); rec_if.i_rec_ready = 1'b0;
    chk("t1_popped", rec_if.o_rec_valid, 1'b0);

    // T2: RMC-only filter
    cfg(2'd0, ID_RMC, 1'b1);
    send(TK_GP, ID_GGA, 8'd14, 1'b1);
    chk("t2_gga_filtered", rec_if.o_rec_valid, 1'b0);
    chk("t2_locked", locked, 1'b1);
    send(TK_GP, ID_RMC, 8'd12, 1'b1);
    d = rec_if.o_rec_data;
    chk("t2_rmc_valid", rec_if.o_rec_valid, 1'b1);
    chk("t2_rmc_data", d, {8'd12, 24'h434D52, 16'h5047});
    rec_if.i_rec_ready = 1'b1; step(); rec_if.i_rec_ready = 1'b0;
    cfg(2'd0, ID_RMC, 1'b0);

    // T3: overflow, then simultaneous push/pop while full
    for (int i = 0; i < 5; i++) begin
      send(TK_GP, ID_GGA, 8'(i + 1), 1'b1);
      chk("t3_drop", drop, i == 4);
    end
    rec_if.i_rec_ready = 1'b1;
    send(TK_GP, ID_GGA, 8'd9, 1'b1);
    chk("t3_full_pushpop_nodrop", drop, 1'b0);
    n = 0;
    while (rec_if.o_rec_valid && n < 10) begin step(); n++; end
    chk("t3_occupancy", n, 4);
    rec_if.i_rec_ready = 1'b0;

    // T4: watchdog expiry from LOCKED, then good sentence in the expiry cycle
    send(TK_GP, ID_GGA, 8'd1, 1'b1);
    repeat (TIMEOUT - 1) step();
    chk("t4_still_locked", locked, 1'b1);
    step();
    chk("t4_lost_locked", locked, 1'b0);
    chk("t4_lost_flush", rx_flush, 1'b1);
    chk("t4_lost_rx_en", rx_en, 1'b0);
    step();
    chk("t4_hunt_flush", rx_flush, 1'b0);
    chk("t4_hunt_rx_en", rx_en, 1'b1);
    send(TK_GP, ID_GGA, 8'd2, 1'b1);
    repeat (TIMEOUT - 1) step();
    send(TK_GP, ID_GGA, 8'd3, 1'b1);
    chk("t4_race_locked", locked, 1'b1);
    chk("t4_race_flush", rx_flush, 1'b0);
    step();
    chk("t4_race_locked2", locked, 1'b1);

    // T5: bad checksums only, from HUNT
    en = 1'b0; step();
    chk("t5_dis_valid", rec_if.o_rec_valid, 1'b0);
    en = 1'b1; step();
    repeat (3) send(TK_GP, ID_GGA, 8'd4, 1'b0);
    chk("t5_no_lock", locked, 1'b0);
    chk("t5_no_push", rec_if.o_rec_valid, 1'b0);
    chk("t5_hunt", rx_en, 1'b1);

    // T6: disable/reset with records queued; filters survive disable, not reset
    repeat (3) send(TK_GP, ID_GGA, 8'd5, 1'b1);
    chk("t6_queued", rec_if.o_rec_valid, 1'b1);
    cfg(2'd1, ID_GSV, 1'b1);
    en = 1'b0; step();
    chk("t6_en_flush", rec_if.o_rec_valid, 1'b0);
    en = 1'b1; step();
    send(TK_GP, ID_GGA, 8'd6, 1'b1);
    chk("t6_filter_kept", rec_if.o_rec_valid, 1'b0);
    send(TK_GP, ID_GSV, 8'd7, 1'b1);
    rst = 1'b1; step();
    chk("t6_rst_flush", rec_if.o_rec_valid, 1'b0);
    rst = 1'b0; step();
    send(TK_GP, ID_GGA, 8'd8, 1'b1);
    chk("t6_filter_cleared", rec_if.o_rec_valid, 1'b1);

    // Randomized traffic in busy and quiet bursts
    for (int b = 0; b < 30; b++) begin
      bit quiet;
      int len;
      quiet = ($urandom_range(0, 2) == 0);
      len   = $urandom_range(60, 250);
      for (int c = 0; c < len; c++) begin
        int r;
        r = $urandom_range(0, 99);
        rec_if.i_rec_ready = ($urandom_range(0, 2) != 0);
        s_done   = !quiet && (r < 25);
        s_check  = ($urandom_range(0, 3) != 0);
        s_id     = ids[$urandom_range(0, 2)];
        s_talker = 16'($urandom);
        s_fields = 8'($urandom);
        cfg_we   = (r >= 97);
        cfg_idx  = 2'($urandom_range(0, 3));
        cfg_id   = ids[$urandom_range(0, 2)];
        cfg_on   = ($urandom_range(0, 1) == 1);
        en       = (r != 50);
        rst      = (r == 51) && ($urandom_range(0, 3) == 0);
        step();
      end
    end
    s_done = 1'b0; cfg_we = 1'b0; rst = 1'b0; en = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
